ex_hazard_controller: RTL and testbench
=======================================

Name: ex_hazard_controller

Overview:
- Pipeline hazard controller for the 5-stage RV32I core, sitting beside the ID/EX pipeline register.
- Shadows the destination registers of the instructions in EX and MEM, and computes registered forward-mux codes that EX consumes together with its operands.
- Detects load-use hazards and inserts a one-cycle stall plus bubble.
- Sequences pipeline squash when EX raises flush; keeps saturating stall/flush counters.

Parameters:
FLUSH_CYCLES, 1, cycles squash_id_op stays high after flush_ip (1..3; covers fetch latency)
CNT_W, 16, width of the stall and flush event counters

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset
id_valid_ip  input  1  ID holds a valid instruction
id_rs1_addr_ip  input  5  source register 1
id_rs2_addr_ip  input  5  source register 2
id_rs1_used_ip  input  1  instruction reads rs1
id_rs2_used_ip  input  1  instruction reads rs2
id_rd_addr_ip  input  5  destination register
id_reg_write_ip  input  1  instruction writes rd
id_is_load_ip  input  1  instruction is a load
id_is_store_ip  input  1  instruction is a store (rs2 is store data)
flush_ip  input  1  taken branch/jump resolved in EX
fa_mux_op  output  forward_mux_code  operand A select, aligned with the instruction in EX
fb_mux_op  output  forward_mux_code  operand B / store-data select, aligned with the instruction in EX
stall_if_op  output  1  hold the PC
stall_id_op  output  1  hold the IF/ID register
bubble_ex_op  output  1  load a NOP into ID/EX this edge
squash_id_op  output  1  invalidate IF/ID this edge
stall_cnt_op  output  CNT_W  load-use stalls taken, saturating
flush_cnt_op  output  CNT_W  flushes taken, saturating

Behaviour:
- Reset (reset=0, async):
  - fa/fb = NO_FORWARD; all control outputs 0; counters 0; slots invalid; state RUN.
- Shadow slots {valid, rd, reg_write, is_load}:
  - ex_slot is loaded from ID on each edge. On a bubble it is loaded invalid.
  - mem_slot <= ex_slot every edge; EX/MEM never stalls.
- A slot "matches" register r when: valid & reg_write & rd==r & rd!=0 & the source is used.
- Forward codes are computed combinationally from ID and registered on the edge that moves ID into EX.
  - rs1 matches ex_slot (non-load) -> EX_RESULT_SELECT.
  - Otherwise rs1 matches mem_slot -> WB_RESULT_SELECT.
  - Otherwise -> NO_FORWARD.
  - The ex_slot match has priority over the mem_slot match.
- rs2 uses the same rules:
  - Non-store: EX_RESULT_SELECT / WB_RESULT_SELECT.
  - Store: MEM_DATA_EX_SELECT / MEM_DATA_WB_SELECT instead.
- Older writers rely on the write-through register file; no code is needed for them.
- On a bubble or squash, the registered codes are NO_FORWARD.
- Load-use: ex_slot.is_load matches rs1 or rs2 of a valid ID instruction (this includes store data).
  - Effect: stall_if_op = stall_id_op = bubble_ex_op = 1 for exactly 1 cycle.
  - Next cycle the load sits in MEM/WB and the consumer receives WB_RESULT_SELECT / MEM_DATA_WB_SELECT.
  - Outputs are combinational in RUN; the FSM records LOAD_STALL for one cycle so that a second stall is not taken on the same pair.
- FSM states and transitions:
  - RUN -> LOAD_STALL on a load-use hazard.
  - LOAD_STALL -> RUN unconditionally.
  - Any state -> FLUSH on flush_ip.
  - FLUSH counts FLUSH_CYCLES, then -> RUN.
- Flush behaviour:
  - On flush_ip: bubble_ex_op = 1 and squash_id_op = 1 in the same cycle; squash_id_op stays high for FLUSH_CYCLES total cycles.
  - Stall outputs are forced to 0 and ex_slot is invalidated.
  - Flush has priority over a load-use stall in the same cycle. The stall is dropped and not counted.
  - flush_ip during FLUSH restarts the count.
  - ID hazards are ignored while squashing.
- Counters increment by 1 per event and saturate at all ones; no wrap.
- Reset mid-stall or mid-flush returns to RUN immediately; no pending state survives.
- Latency: codes valid in EX the cycle after ID presents the instruction; stall/flush outputs are same-cycle combinational.

Decomposition:
- CORE_PKG gains:
  - hazard_state_e {RUN, LOAD_STALL, FLUSH};
  - slot_t struct.
- forward_mux_code (NO_FORWARD, EX_RESULT_SELECT, WB_RESULT_SELECT, MEM_DATA_EX_SELECT, MEM_DATA_WB_SELECT) stays in CORE_PKG.
- One sub-module, forward_select: a combinational slot compare that is instantiated once each for rs1 and rs2 and returns the code.

Test Plan:
- addi x5 then add x6,x5,x5 back-to-back -> fa=fb=EX_RESULT_SELECT in EX of add; no stall.
- addi x5; nop; sub x7,x5,x1 -> fa=WB_RESULT_SELECT, fb=NO_FORWARD.
- lw x5; add x6,x5,x2 -> one cycle of stall_if/stall_id/bubble_ex; then fa=WB_RESULT_SELECT; stall_cnt_op=1.
- addi x5; sw x5,0(x2) -> fb=MEM_DATA_EX_SELECT; write to x0 followed by a reader of x0 -> NO_FORWARD.
- lw x5 followed by a dependent instruction, with flush_ip=1 in the same cycle, FLUSH_CYCLES=2:
  - squash_id high for 2 cycles; no stall.
  - flush_cnt_op=1, stall_cnt_op=0.
- Force stall_cnt_op to 0xFFFF, then trigger another load-use -> stays 0xFFFF. Assert reset low mid-FLUSH -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_hazard_controller_pkg.sv
// ----------------------------------------------------------------------------
// ex_hazard_controller_pkg
// Shared types for the EX hazard controller of the 5-stage RV32I core:
//   forward_mux_code : operand select codes consumed by the EX stage
//   hazard_state_e   : controller FSM states
//   slot_t           : shadow copy of an in-flight instruction's write info
//   slot_hits()      : "does this slot write register r for a used source"
// ----------------------------------------------------------------------------
package ex_hazard_controller_pkg;

    typedef enum logic [2:0] {
        NO_FORWARD         = 3'd0,
        EX_RESULT_SELECT   = 3'd1,
        WB_RESULT_SELECT   = 3'd2,
        MEM_DATA_EX_SELECT = 3'd3,
        MEM_DATA_WB_SELECT = 3'd4
    } forward_mux_code;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } slot_t;

    // A slot supplies register r when it is live, writes a non-zero rd equal
    // to r and the consumer actually reads r. allow_load=0 excludes loads,
    // whose data is not yet available while they sit in EX.
    function automatic logic slot_hits(slot_t s, logic [4:0] r, logic used,
                                       logic allow_load);
        return s.valid & s.reg_write & (s.rd == r) & (s.rd != 5'd0) & used &
               (allow_load | ~s.is_load);
    endfunction

endpackage

// File: rtl/ex_hazard_controller_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_controller_if
// Groups the ID-side request signals and the controller's responses.
//   master : pipeline side (drives ID fields and flush_ip)
//   slave  : hazard controller side
// ----------------------------------------------------------------------------
interface ex_hazard_controller_if
    import ex_hazard_controller_pkg::*;
#(
    parameter int CNT_W = 16
) ();
    logic             id_valid_ip;
    logic [4:0]       id_rs1_addr_ip;
    logic [4:0]       id_rs2_addr_ip;
    logic             id_rs1_used_ip;
    logic             id_rs2_used_ip;
    logic [4:0]       id_rd_addr_ip;
    logic             id_reg_write_ip;
    logic             id_is_load_ip;
    logic             id_is_store_ip;
    logic             flush_ip;
    forward_mux_code  fa_mux_op;
    forward_mux_code  fb_mux_op;
    logic             stall_if_op;
    logic             stall_id_op;
    logic             bubble_ex_op;
    logic             squash_id_op;
    logic [CNT_W-1:0] stall_cnt_op;
    logic [CNT_W-1:0] flush_cnt_op;

    modport master (
        output id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_rs1_used_ip,
               id_rs2_used_ip, id_rd_addr_ip, id_reg_write_ip, id_is_load_ip,
               id_is_store_ip, flush_ip,
        input  fa_mux_op, fb_mux_op, stall_if_op, stall_id_op, bubble_ex_op,
               squash_id_op, stall_cnt_op, flush_cnt_op
    );

    modport slave (
        input  id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip, id_rs1_used_ip,
               id_rs2_used_ip, id_rd_addr_ip, id_reg_write_ip, id_is_load_ip,
               id_is_store_ip, flush_ip,
        output fa_mux_op, fb_mux_op, stall_if_op, stall_id_op, bubble_ex_op,
               squash_id_op, stall_cnt_op, flush_cnt_op
    );
endinterface

// File: rtl/ex_hazard_controller_forward_select.sv
// ----------------------------------------------------------------------------
// forward_select
// Combinational forward-code selection for one source operand.
//   ex_slot_i       : writer currently in EX
//   mem_slot_i      : writer currently in MEM
//   rs_addr_i       : source register read by the ID instruction
//   rs_used_i       : the source is actually read
//   is_store_data_i : operand is store data (selects MEM_DATA_* codes)
//   code_o          : resulting forward code
// ----------------------------------------------------------------------------
module forward_select
    import ex_hazard_controller_pkg::*;
(
    input  slot_t           ex_slot_i,
    input  slot_t           mem_slot_i,
    input  logic [4:0]      rs_addr_i,
    input  logic            rs_used_i,
    input  logic            is_store_data_i,
    output forward_mux_code code_o
);

    // Younger writer (EX) wins over older writer (MEM); loads in EX never
    // forward because their data only exists after MEM.
    always_comb begin
        code_o = NO_FORWARD;
        if (slot_hits(ex_slot_i, rs_addr_i, rs_used_i, 1'b0)) begin
            code_o = is_store_data_i ? MEM_DATA_EX_SELECT : EX_RESULT_SELECT;
        end else if (slot_hits(mem_slot_i, rs_addr_i, rs_used_i, 1'b1)) begin
            code_o = is_store_data_i ? MEM_DATA_WB_SELECT : WB_RESULT_SELECT;
        end else begin
            code_o = NO_FORWARD;
        end
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// ----------------------------------------------------------------------------
// ex_hazard_controller
// Hazard controller beside the ID/EX register of the 5-stage RV32I core.
// Shadows the EX and MEM destinations, registers forward codes for EX,
// inserts a one-cycle load-use stall and sequences squash on flush.
//   clock : core clock
//   reset : asynchronous active-low reset
//   hz    : slave modport carrying ID fields, flush_ip, forward codes,
//           stall/bubble/squash controls and saturating event counters
// Parameters: FLUSH_CYCLES (1..3) squash length, CNT_W counter width.
// ----------------------------------------------------------------------------
module ex_hazard_controller
    import ex_hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    ex_hazard_controller_if.slave hz
);

    localparam logic [1:0]       FLUSH_REM_INIT = 2'(FLUSH_CYCLES - 1);
    localparam hazard_state_e    FLUSH_ENTRY    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    hazard_state_e   state_q, state_d, run_next_s;
    logic [1:0]      flush_rem_q, flush_rem_d, run_rem_s;
    slot_t           ex_slot_q, ex_slot_d;
    slot_t           mem_slot_q;
    forward_mux_code fa_q, fa_d, fb_q, fb_d;
    forward_mux_code fa_s, fb_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic            squash_s;
    logic            load_use_s;
    logic            bubble_s;
    logic            id_live_s;

    forward_select u_fwd_rs1 (
        .ex_slot_i       (ex_slot_q),
        .mem_slot_i      (mem_slot_q),
        .rs_addr_i       (hz.id_rs1_addr_ip),
        .rs_used_i       (hz.id_rs1_used_ip),
        .is_store_data_i (1'b0),
        .code_o          (fa_s)
    );

    forward_select u_fwd_rs2 (
        .ex_slot_i       (ex_slot_q),
        .mem_slot_i      (mem_slot_q),
        .rs_addr_i       (hz.id_rs2_addr_ip),
        .rs_used_i       (hz.id_rs2_used_ip),
        .is_store_data_i (hz.id_is_store_ip),
        .code_o          (fb_s)
    );

    // Hazard detection: squash covers the flush cycle plus the FLUSH state;
    // a load-use stall is only taken from RUN and never alongside a flush.
    always_comb begin
        squash_s   = hz.flush_ip | (state_q == FLUSH);
        load_use_s = 1'b0;
        if ((state_q == RUN) && !hz.flush_ip && hz.id_valid_ip && ex_slot_q.is_load) begin
            load_use_s = slot_hits(ex_slot_q, hz.id_rs1_addr_ip, hz.id_rs1_used_ip, 1'b1) |
                         slot_hits(ex_slot_q, hz.id_rs2_addr_ip, hz.id_rs2_used_ip, 1'b1);
        end else begin
            load_use_s = 1'b0;
        end
        bubble_s  = hz.flush_ip | load_use_s;
        id_live_s = hz.id_valid_ip & ~bubble_s & ~squash_s;
    end

    // Next-state: normal progression first, then flush overrides everything.
    always_comb begin
        run_next_s = state_q;
        run_rem_s  = flush_rem_q;
        case (state_q)
            RUN: begin
                run_next_s = load_use_s ? LOAD_STALL : RUN;
            end
            LOAD_STALL: begin
                run_next_s = RUN;
            end
            FLUSH: begin
                if (flush_rem_q <= 2'd1) begin
                    run_next_s = RUN;
                    run_rem_s  = 2'd0;
                end else begin
                    run_next_s = FLUSH;
                    run_rem_s  = flush_rem_q - 2'd1;
                end
            end
            default: begin
                run_next_s = RUN;
                run_rem_s  = 2'd0;
            end
        endcase
        state_d     = hz.flush_ip ? FLUSH_ENTRY : run_next_s;
        flush_rem_d = hz.flush_ip ? FLUSH_REM_INIT : run_rem_s;
    end

    // Datapath next values: EX shadow, registered forward codes, counters.
    always_comb begin
        ex_slot_d.valid     = id_live_s;
        ex_slot_d.rd        = hz.id_rd_addr_ip;
        ex_slot_d.reg_write = hz.id_reg_write_ip;
        ex_slot_d.is_load   = hz.id_is_load_ip;
        fa_d = id_live_s ? fa_s : NO_FORWARD;
        fb_d = id_live_s ? fb_s : NO_FORWARD;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (hz.flush_ip && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, shadow slots, codes and counters; EX/MEM advances every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            flush_rem_q <= 2'd0;
            ex_slot_q   <= '0;
            mem_slot_q  <= '0;
            fa_q        <= NO_FORWARD;
            fb_q        <= NO_FORWARD;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_rem_q <= flush_rem_d;
            ex_slot_q   <= ex_slot_d;
            mem_slot_q  <= ex_slot_q;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Control outputs are same-cycle; gating with reset keeps them quiet
    // while reset is held even if flush_ip is still asserted.
    assign hz.stall_if_op  = load_use_s & reset;
    assign hz.stall_id_op  = load_use_s & reset;
    assign hz.bubble_ex_op = bubble_s & reset;
    assign hz.squash_id_op = squash_s & reset;
    assign hz.fa_mux_op    = fa_q;
    assign hz.fb_mux_op    = fb_q;
    assign hz.stall_cnt_op = stall_cnt_q;
    assign hz.flush_cnt_op = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Self-checking bench for ex_hazard_controller: directed instruction
// sequences plus randomized traffic against a pipeline-level model.
module tb_ex_hazard_controller;
    import ex_hazard_controller_pkg::*;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ex_hazard_controller_if #(.CNT_W(CW)) hz ();

    ex_hazard_controller #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: what occupies EX and MEM, what EX was told to select,
    // how many squash cycles remain, whether the last cycle stalled.
    bit m_ex_v, m_ex_w, m_ex_ld;
    int m_ex_rd;
    bit m_mem_v, m_mem_w;
    int m_mem_rd;
    int m_fa, m_fb;
    int m_sq_left;
    bit m_stalled;
    int m_scnt, m_fcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ex_v = 0; m_ex_w = 0; m_ex_ld = 0; m_ex_rd = 0;
        m_mem_v = 0; m_mem_w = 0; m_mem_rd = 0;
        m_fa = int'(NO_FORWARD); m_fb = int'(NO_FORWARD);
        m_sq_left = 0; m_stalled = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    function automatic int model_code(int rs, bit used, bit store);
        if (!used || rs == 0) return int'(NO_FORWARD);
        if (m_ex_v && m_ex_w && !m_ex_ld && m_ex_rd == rs)
            return store ? int'(MEM_DATA_EX_SELECT) : int'(EX_RESULT_SELECT);
        if (m_mem_v && m_mem_w && m_mem_rd == rs)
            return store ? int'(MEM_DATA_WB_SELECT) : int'(WB_RESULT_SELECT);
        return int'(NO_FORWARD);
    endfunction

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit w, input bit ld, input bit st);
        hz.id_valid_ip     = v;
        hz.id_rs1_addr_ip  = 5'(rs1);
        hz.id_rs1_used_ip  = u1;
        hz.id_rs2_addr_ip  = 5'(rs2);
        hz.id_rs2_used_ip  = u2;
        hz.id_rd_addr_ip   = 5'(rd);
        hz.id_reg_write_ip = w;
        hz.id_is_load_ip   = ld;
        hz.id_is_store_ip  = st;
    endtask

    task automatic set_idle();
        set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        hz.flush_ip = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step(input bit fl, output bit stalled);
        bit squashing, luse, live;
        int rs1, rs2, nfa, nfb;
        hz.flush_ip = fl;
        @(negedge clock);
        rs1 = int'(hz.id_rs1_addr_ip);
        rs2 = int'(hz.id_rs2_addr_ip);
        squashing = fl || (m_sq_left > 0);
        luse = !squashing && !m_stalled && hz.id_valid_ip && m_ex_v && m_ex_w && m_ex_ld &&
               (m_ex_rd != 0) &&
               ((hz.id_rs1_used_ip && rs1 == m_ex_rd) || (hz.id_rs2_used_ip && rs2 == m_ex_rd));
        check_eq("fa_mux",    32'(hz.fa_mux_op),    32'(m_fa));
        check_eq("fb_mux",    32'(hz.fb_mux_op),    32'(m_fb));
        check_eq("stall_if",  32'(hz.stall_if_op),  32'(luse));
        check_eq("stall_id",  32'(hz.stall_id_op),  32'(luse));
        check_eq("bubble_ex", 32'(hz.bubble_ex_op), 32'(luse || fl));
        check_eq("squash_id", 32'(hz.squash_id_op), 32'(squashing));
        check_eq("stall_cnt", 32'(hz.stall_cnt_op), 32'(m_scnt));
        check_eq("flush_cnt", 32'(hz.flush_cnt_op), 32'(m_fcnt));
        live = hz.id_valid_ip && !luse && !squashing;
        nfa  = live ? model_code(rs1, hz.id_rs1_used_ip, 1'b0) : int'(NO_FORWARD);
        nfb  = live ? model_code(rs2, hz.id_rs2_used_ip, hz.id_is_store_ip) : int'(NO_FORWARD);
        m_mem_v = m_ex_v; m_mem_w = m_ex_w; m_mem_rd = m_ex_rd;
        m_ex_v = live; m_ex_w = hz.id_reg_write_ip; m_ex_ld = hz.id_is_load_ip;
        m_ex_rd = int'(hz.id_rd_addr_ip);
        m_fa = nfa; m_fb = nfb;
        if (fl) m_sq_left = FC - 1;
        else if (m_sq_left > 0) m_sq_left--;
        m_stalled = luse;
        if (luse && m_scnt < CMAX) m_scnt++;
        if (fl && m_fcnt < CMAX) m_fcnt++;
        @(posedge clock);
        #1;
        stalled = luse;
    endtask

    // Present one instruction and keep it in ID while the stall lasts.
    task automatic issue(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit w, input bit ld, input bit st, input bit fl);
        bit s;
        set_id(v, rs1, u1, rs2, u2, rd, w, ld, st);
        step(fl, s);
        for (int i = 0; i < 3 && s; i++) step(1'b0, s);
        check_eq("stall_release", 32'(s), 32'd0);
        hz.flush_ip = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clock);
        reset = 1'b0;
        #2;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit s;
        set_idle();
        model_reset();
        #12;
        check_eq("rst_fa",     32'(hz.fa_mux_op),    32'(NO_FORWARD));
        check_eq("rst_fb",     32'(hz.fb_mux_op),    32'(NO_FORWARD));
        check_eq("rst_squash", 32'(hz.squash_id_op), 32'd0);
        check_eq("rst_cnt",    32'(hz.stall_cnt_op), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // addi x5 ; add x6,x5,x5
        issue(1'b1, 0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("raw_ex_fa", 32'(hz.fa_mux_op), 32'(EX_RESULT_SELECT));
        check_eq("raw_ex_fb", 32'(hz.fb_mux_op), 32'(EX_RESULT_SELECT));

        // addi x5 ; nop ; sub x7,x5,x1
        issue(1'b1, 0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 5, 1'b1, 1, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("raw_wb_fa", 32'(hz.fa_mux_op), 32'(WB_RESULT_SELECT));
        check_eq("raw_wb_fb", 32'(hz.fb_mux_op), 32'(NO_FORWARD));

        // lw x5 ; add x6,x5,x2
        do_reset();
        issue(1'b1, 2, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5, 1'b1, 2, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_fa",  32'(hz.fa_mux_op),    32'(WB_RESULT_SELECT));
        check_eq("lu_cnt", 32'(hz.stall_cnt_op), 32'd1);

        // addi x5 ; sw x5,0(x2) ; addi x0 ; add x1,x0,x0
        issue(1'b1, 0, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 2, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("st_fb", 32'(hz.fb_mux_op), 32'(MEM_DATA_EX_SELECT));
        issue(1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 0, 1'b1, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("x0_fa", 32'(hz.fa_mux_op), 32'(NO_FORWARD));
        check_eq("x0_fb", 32'(hz.fb_mux_op), 32'(NO_FORWARD));

        // lw x5 ; dependent add with flush in the same cycle
        do_reset();
        issue(1'b1, 2, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 5, 1'b1, 2, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
        set_idle();
        #1;
        check_eq("fl_squash2", 32'(hz.squash_id_op), 32'd1);
        check_eq("fl_nostall", 32'(hz.stall_if_op),  32'd0);
        step(1'b0, s);
        check_eq("fl_squash_end", 32'(hz.squash_id_op), 32'd0);
        check_eq("fl_fcnt",       32'(hz.flush_cnt_op), 32'd1);
        check_eq("fl_scnt",       32'(hz.stall_cnt_op), 32'd0);

        // Reset asserted while in FLUSH
        issue(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_idle();
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_squash", 32'(hz.squash_id_op), 32'd0);
        check_eq("mid_rst_bubble", 32'(hz.bubble_ex_op), 32'd0);
        check_eq("mid_rst_fcnt",   32'(hz.flush_cnt_op), 32'd0);
        check_eq("mid_rst_fa",     32'(hz.fa_mux_op),    32'(NO_FORWARD));
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, s);

        // Stall counter saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            issue(1'b1, 2, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
            issue(1'b1, 1, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_eq("sat_scnt", 32'(hz.stall_cnt_op), 32'(CMAX));

        // Randomized traffic over a small register set, ID held on stall
        s = 1'b0;
        for (int c = 0; c < 800; c++) begin
            bit fl;
            if (!s) begin
                bit v, ld, st;
                v  = ($urandom_range(0, 9) < 8);
                ld = ($urandom_range(0, 2) == 0);
                st = !ld && ($urandom_range(0, 3) == 0);
                set_id(v, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                       st ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       !st && ($urandom_range(0, 5) != 0), ld, st);
            end
            fl = ($urandom_range(0, 11) == 0);
            step(fl, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
